// File: rtl/writeback_stage.sv
// Writeback stage: selects the register-file write source, extracts loads and stalls on MDU results.
// Optional macro WB_FORWARD_EN adds the fwd_valid/fwd_idx/fwd_data bypass outputs.
module writeback_stage #(
  parameter int DATA_BITS    = 32,
  parameter int REG_IDX_BITS = 5,
  parameter int LINK_REG     = 31
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REG_IDX_BITS-1:0]       rt,
  input  logic [REG_IDX_BITS-1:0]       rd,
  input  logic [DATA_BITS-1:0]          alu_out,
  input  logic [DATA_BITS-1:0]          mem_out,
  input  logic [DATA_BITS-1:0]          pc,
  input  logic [$clog2(DATA_BITS/8)-1:0] addr_lo,
  input  logic                          Jal,
  input  logic                          RegDst,
  input  logic                          MemToReg,
  input  logic                          ExtrSigned,
  input  logic [1:0]                    ExtrWord,
  input  logic [1:0]                    LHToReg,
  input  logic                          mdu_busy,
  input  logic                          mdu_done,
  input  logic [DATA_BITS-1:0]          lo,
  input  logic [DATA_BITS-1:0]          hi,
  output logic                          we,
  output logic [REG_IDX_BITS-1:0]       waddr,
  output logic [DATA_BITS-1:0]          wdata,
  output logic                          stalled
`ifdef WB_FORWARD_EN
  ,
  output logic                          fwd_valid,
  output logic [REG_IDX_BITS-1:0]       fwd_idx,
  output logic [DATA_BITS-1:0]          fwd_data
`endif
);

  localparam int AW = $clog2(DATA_BITS/8);
  localparam logic [REG_IDX_BITS-1:0] LINK_IDX = REG_IDX_BITS'(LINK_REG);
  localparam logic [REG_IDX_BITS-1:0] ZERO_IDX = {REG_IDX_BITS{1'b0}};

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_MDU = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [REG_IDX_BITS-1:0] pend_idx_q, pend_idx_d;
  logic [1:0]              pend_sel_q, pend_sel_d;
  logic                    we_q, we_d;
  logic [REG_IDX_BITS-1:0] waddr_q, waddr_d;
  logic [DATA_BITS-1:0]    wdata_q, wdata_d;
  logic [REG_IDX_BITS-1:0] dest_s;

  function automatic logic [DATA_BITS-1:0] extract_load(
    input logic [DATA_BITS-1:0] d,
    input logic [AW-1:0]        a_lo,
    input logic [1:0]           sz,
    input logic                 sgn
  );
    logic [DATA_BITS-1:0] sh_b;
    logic [DATA_BITS-1:0] sh_h;
    logic [7:0]           b;
    logic [15:0]          h;
    logic [DATA_BITS-1:0] r;
    sh_b = d >> {a_lo, 3'b000};
    sh_h = d >> {a_lo[AW-1:1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (sz)
      2'd0:    r = d;
      2'd1:    r = {{(DATA_BITS-8){b[7] & sgn}}, b};
      2'd2:    r = {{(DATA_BITS-16){h[15] & sgn}}, h};
      default: r = {DATA_BITS{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [DATA_BITS-1:0] mdu_pick(
    input logic [1:0]           sel,
    input logic [DATA_BITS-1:0] lo_v,
    input logic [DATA_BITS-1:0] hi_v
  );
    logic [DATA_BITS-1:0] r;
    case (sel)
      2'd1:    r = lo_v;
      2'd2:    r = hi_v;
      default: r = {DATA_BITS{1'b0}};
    endcase
    return r;
  endfunction

  assign dest_s = RegDst ? rd : rt;

  // Next-state and next-write computation for both FSM states.
  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    pend_sel_d = pend_sel_q;
    we_d       = 1'b0;
    waddr_d    = ZERO_IDX;
    wdata_d    = {DATA_BITS{1'b0}};
    case (state_q)
      RUN: begin
        if (in_valid) begin
          if (Jal) begin
            waddr_d = LINK_IDX;
            wdata_d = pc;
            we_d    = (LINK_IDX != ZERO_IDX);
          end else if (MemToReg) begin
            waddr_d = dest_s;
            wdata_d = extract_load(mem_out, addr_lo, ExtrWord, ExtrSigned);
            we_d    = (dest_s != ZERO_IDX);
          end else if (LHToReg != 2'd0) begin
            // A busy MDU without a result parks the request; the write is issued on mdu_done.
            if (mdu_busy && !mdu_done) begin
              state_d    = WAIT_MDU;
              pend_idx_d = dest_s;
              pend_sel_d = LHToReg;
            end else begin
              waddr_d = dest_s;
              wdata_d = mdu_pick(LHToReg, lo, hi);
              we_d    = (dest_s != ZERO_IDX);
            end
          end else begin
            waddr_d = dest_s;
            wdata_d = alu_out;
            we_d    = (dest_s != ZERO_IDX);
          end
        end else begin
          we_d = 1'b0;
        end
      end
      WAIT_MDU: begin
        if (mdu_done) begin
          state_d = RUN;
          waddr_d = pend_idx_q;
          wdata_d = mdu_pick(pend_sel_q, lo, hi);
          we_d    = (pend_idx_q != ZERO_IDX);
        end else begin
          state_d = WAIT_MDU;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // FSM state, pending MDU request and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pend_idx_q <= ZERO_IDX;
      pend_sel_q <= 2'd0;
      we_q       <= 1'b0;
      waddr_q    <= ZERO_IDX;
      wdata_q    <= {DATA_BITS{1'b0}};
    end else begin
      state_q    <= state_d;
      pend_idx_q <= pend_idx_d;
      pend_sel_q <= pend_sel_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign in_ready = (state_q == RUN);
  assign stalled  = (state_q == WAIT_MDU);

`ifdef WB_FORWARD_EN
  assign fwd_valid = we_d && (state_q == RUN);
  assign fwd_idx   = waddr_d;
  assign fwd_data  = wdata_d;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (DATA_BITS=32, REG_IDX_BITS=5, LINK_REG=31).
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rt, rd;
  logic [31:0] alu_out, mem_out, pc;
  logic [1:0]  addr_lo;
  logic        Jal, RegDst, MemToReg, ExtrSigned;
  logic [1:0]  ExtrWord, LHToReg;
  logic        mdu_busy, mdu_done;
  logic [31:0] lo, hi;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stalled;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] fwd_data;
`endif

  int n_cmp;
  int n_err;

  writeback_stage #(.DATA_BITS(32), .REG_IDX_BITS(5), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rt(rt), .rd(rd), .alu_out(alu_out), .mem_out(mem_out), .pc(pc),
    .addr_lo(addr_lo), .Jal(Jal), .RegDst(RegDst), .MemToReg(MemToReg),
    .ExtrSigned(ExtrSigned), .ExtrWord(ExtrWord), .LHToReg(LHToReg),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .lo(lo), .hi(hi),
    .we(we), .waddr(waddr), .wdata(wdata), .stalled(stalled)
`ifdef WB_FORWARD_EN
    , .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; rt = 5'd0; rd = 5'd0;
    alu_out = 32'h0; mem_out = 32'h0; pc = 32'h0; addr_lo = 2'd0;
    Jal = 1'b0; RegDst = 1'b0; MemToReg = 1'b0; ExtrSigned = 1'b0;
    ExtrWord = 2'd0; LHToReg = 2'd0; mdu_busy = 1'b0; mdu_done = 1'b0;
    lo = 32'h0; hi = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sz, input logic sgn, input logic [1:0] al,
                      input logic [31:0] m, input logic [4:0] dst);
    @(negedge clk);
    idle();
    in_valid = 1'b1; MemToReg = 1'b1; ExtrWord = sz; ExtrSigned = sgn;
    addr_lo = al; mem_out = m; rt = dst;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;
    #3;
    chk("reset_we", we, 1'b0);
    chk("reset_waddr", waddr, 5'd0);
    chk("reset_wdata", wdata, 32'h0);
    chk("reset_stalled", stalled, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed byte load, lane 2
    load(2'd1, 1'b1, 2'd2, 32'h12803456, 5'd5);
    tick();
    chk("sbyte_we", we, 1'b1);
    chk("sbyte_waddr", waddr, 5'd5);
    chk("sbyte_wdata", wdata, 32'hFFFFFF80);
    @(negedge clk);
    idle();
    tick();
    chk("one_cycle_we", we, 1'b0);

    // Back-to-back load variants
    load(2'd1, 1'b0, 2'd2, 32'h12803456, 5'd6);
    tick();
    chk("ubyte_wdata", wdata, 32'h00000080);
    load(2'd1, 1'b1, 2'd0, 32'h12803456, 5'd6);
    tick();
    chk("sbyte0_wdata", wdata, 32'h00000056);
    chk("b2b_we", we, 1'b1);
    load(2'd0, 1'b1, 2'd3, 32'h12803456, 5'd6);
    tick();
    chk("word_wdata", wdata, 32'h12803456);
    load(2'd2, 1'b1, 2'd1, 32'h12348001, 5'd8);
    tick();
    chk("shalf_wdata", wdata, 32'hFFFF8001);
    load(2'd3, 1'b1, 2'd0, 32'hFFFFFFFF, 5'd4);
    tick();
    chk("rsvd_extr_we", we, 1'b1);
    chk("rsvd_extr_wdata", wdata, 32'h0);

    // Unsigned halfword, upper lane, RegDst
    load(2'd2, 1'b0, 2'd3, 32'hBEEF1234, 5'd2);
    RegDst = 1'b1; rd = 5'd9;
    tick();
    chk("uhalf_waddr", waddr, 5'd9);
    chk("uhalf_wdata", wdata, 32'h0000BEEF);

    // Jal beats MemToReg
    load(2'd0, 1'b0, 2'd0, 32'h11111111, 5'd3);
    Jal = 1'b1; pc = 32'h00400010;
    tick();
    chk("jal_we", we, 1'b1);
    chk("jal_waddr", waddr, 5'd31);
    chk("jal_wdata", wdata, 32'h00400010);

    // ALU result through rd
    @(negedge clk);
    idle();
    in_valid = 1'b1; RegDst = 1'b1; rd = 5'd12; rt = 5'd13; alu_out = 32'hA5A50001;
    tick();
    chk("alu_waddr", waddr, 5'd12);
    chk("alu_wdata", wdata, 32'hA5A50001);

    // MemToReg beats LHToReg; LO ready without stall; reserved LHToReg
    load(2'd0, 1'b0, 2'd0, 32'h0BADF00D, 5'd10);
    LHToReg = 2'd1; lo = 32'h11112222; mdu_busy = 1'b1;
    tick();
    chk("mem_over_lh_wdata", wdata, 32'h0BADF00D);
    chk("mem_over_lh_stall", stalled, 1'b0);
    @(negedge clk);
    idle();
    in_valid = 1'b1; LHToReg = 2'd1; rt = 5'd11; lo = 32'h11112222; hi = 32'h33334444;
    mdu_busy = 1'b1; mdu_done = 1'b1;
    tick();
    chk("lo_done_stalled", stalled, 1'b0);
    chk("lo_done_waddr", waddr, 5'd11);
    chk("lo_done_wdata", wdata, 32'h11112222);
    @(negedge clk);
    idle();
    in_valid = 1'b1; LHToReg = 2'd3; rt = 5'd14; lo = 32'h5; hi = 32'h6;
    tick();
    chk("lh_rsvd_we", we, 1'b1);
    chk("lh_rsvd_wdata", wdata, 32'h0);

    // Zero register suppresses the write
    @(negedge clk);
    idle();
    in_valid = 1'b1; rt = 5'd0; alu_out = 32'h55;
    tick();
    chk("zero_reg_we", we, 1'b0);
    chk("zero_reg_ready", in_ready, 1'b1);

    // MDU stall on HI, competing request held upstream
    @(negedge clk);
    idle();
    in_valid = 1'b1; LHToReg = 2'd2; RegDst = 1'b1; rd = 5'd7; mdu_busy = 1'b1;
    tick();
    chk("stall_enter_we", we, 1'b0);
    chk("stall_enter_stalled", stalled, 1'b1);
    chk("stall_enter_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      in_valid = 1'b1; rt = 5'd3; alu_out = 32'hDEAD; mdu_busy = 1'b1;
      tick();
      chk("stall_hold_stalled", stalled, 1'b1);
      chk("stall_hold_ready", in_ready, 1'b0);
      chk("stall_hold_we", we, 1'b0);
    end
    @(negedge clk);
    idle();
    mdu_done = 1'b1; hi = 32'hCAFE0001; lo = 32'h12121212;
    tick();
    chk("stall_exit_we", we, 1'b1);
    chk("stall_exit_waddr", waddr, 5'd7);
    chk("stall_exit_wdata", wdata, 32'hCAFE0001);
    chk("stall_exit_stalled", stalled, 1'b0);
    chk("stall_exit_ready", in_ready, 1'b1);
    @(negedge clk);
    idle();
    tick();
    chk("stall_after_we", we, 1'b0);

    // Reset while waiting discards the pending write
    @(negedge clk);
    idle();
    in_valid = 1'b1; LHToReg = 2'd1; RegDst = 1'b1; rd = 5'd9; mdu_busy = 1'b1;
    tick();
    chk("rst_stall_stalled", stalled, 1'b1);
    @(negedge clk);
    idle();
    mdu_busy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stalled", stalled, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b1);
    chk("rst_mid_we", we, 1'b0);
    chk("rst_mid_waddr", waddr, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdu_busy = 1'b0; mdu_done = 1'b1; lo = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_post_we", we, 1'b0);
      chk("rst_post_stalled", stalled, 1'b0);
    end

`ifdef WB_FORWARD_EN
    // Forward outputs predict the next registered write
    for (int i = 0; i < 100; i++) begin
      logic       fv;
      logic [4:0] fi;
      logic [31:0] fd;
      @(negedge clk);
      idle();
      in_valid = 1'($urandom_range(0, 1));
      rt = 5'($urandom); rd = 5'($urandom);
      alu_out = $urandom; mem_out = $urandom; pc = $urandom;
      addr_lo = 2'($urandom); Jal = 1'($urandom_range(0, 3) == 0);
      RegDst = 1'($urandom); MemToReg = 1'($urandom); ExtrSigned = 1'($urandom);
      ExtrWord = 2'($urandom); LHToReg = 2'($urandom);
      mdu_done = 1'b1; lo = $urandom; hi = $urandom;
      #1;
      fv = fwd_valid; fi = fwd_idx; fd = fwd_data;
      tick();
      chk("fwd_valid", we, fv);
      if (fv) begin
        chk("fwd_idx", waddr, fi);
        chk("fwd_data", wdata, fd);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DATA_BITS, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter REG_IDX_BITS, default 5, register index width.
REQ-003 Parameter LINK_REG, default 31, destination index for link writes.
REQ-004 Port list, one per line:
 - clk  input  1  single clock; all state changes on rising edge.
 - rst_n  input  1  asynchronous, active-low reset.
 - in_valid  input  1  writeback request present.
 - in_ready  output  1  stage can accept a request.
 - rt, rd  input  REG_IDX_BITS  candidate destination indices.
 - alu_out, mem_out, pc  input  DATA_BITS  result, load data, link address.
 - addr_lo  input  log2(DATA_BITS/8)  low address bits of the load.
 - Jal, RegDst, MemToReg, ExtrSigned  input  1  source and destination control.
 - ExtrWord  input  2  load size: 0 full word, 1 byte, 2 halfword, 3 reserved.
 - LHToReg  input  2  0 none, 1 LO, 2 HI, 3 reserved.
 - mdu_busy, mdu_done  input  1  multiply/divide unit status.
 - lo, hi  input  DATA_BITS  multiply/divide results, valid while mdu_done=1.
 - we  output  1  register-file write strobe.
 - waddr  output  REG_IDX_BITS  write index.
 - wdata  output  DATA_BITS  write data.
 - stalled  output  1  high while in WAIT_MDU.

Function
REQ-005 A request is accepted on any edge where in_valid=1 and in_ready=1.
REQ-006 Fixed latency: a request accepted at edge N drives we/waddr/wdata from edge N+1 for exactly one cycle. The outputs are registered.
REQ-007 Source priority, highest first: Jal, then MemToReg, then LHToReg!=0, then alu_out.
REQ-008 Jal selects waddr=LINK_REG and wdata=pc. Otherwise waddr=rd if RegDst=1, else rt.
REQ-009 Load extraction when MemToReg=1:
 - Byte: byte lane = addr_lo.
 - Halfword: half lane = addr_lo without its LSB.
 - Word: uses mem_out unmodified.
 - Extension: sign-extend to DATA_BITS when ExtrSigned=1, else zero-extend.
 - ExtrWord=3 writes 0.
REQ-010 LHToReg=3 writes 0.
REQ-011 If waddr=0, we stays 0. The request still counts as accepted.
REQ-012 FSM states: RUN and WAIT_MDU.
 - RUN: in_ready=1.
 - RUN -> WAIT_MDU: a request with LHToReg!=0 (and Jal=0, MemToReg=0) is accepted while mdu_busy=1 and mdu_done=0. The destination index and LO/HI selection are latched, and no write is issued.
 - WAIT_MDU: in_ready=0 and stalled=1.
 - WAIT_MDU -> RUN: on the edge where mdu_done=1. The selected lo/hi value is captured, and the write appears on the next cycle.
REQ-013 If mdu_done=1 in the accept cycle, no stall occurs and the lo/hi value is written with normal latency.
REQ-014 In WAIT_MDU, in_valid is ignored. The upstream stage holds its request.
REQ-015 Back-to-back accepts in RUN produce writes on consecutive cycles with no bubble.

Reset
REQ-016 While rst_n=0, independent of clk:
 - FSM = RUN.
 - we=0, waddr=0, wdata=0, stalled=0.
 - in_ready=1 once the FSM is in RUN.
REQ-017 Reset during WAIT_MDU discards the pending write. No write is issued after reset releases.

Configuration
REQ-018 Macro WB_FORWARD_EN. When defined, the block adds three outputs:
 - fwd_valid (1 bit), fwd_idx (REG_IDX_BITS), fwd_data (DATA_BITS).
 - They are combinational copies of the value that we/waddr/wdata will take on the next edge, so the decode stage can bypass.
 - fwd_valid=0 whenever that write would be suppressed or while in WAIT_MDU.
REQ-019 When WB_FORWARD_EN is not defined, these ports do not exist, and no other behaviour changes.

Verification
REQ-020 Signed byte load: DATA_BITS=32, MemToReg=1, ExtrWord=1, ExtrSigned=1, addr_lo=2, mem_out=0x12_80_34_56, rt=5, RegDst=0 -> one cycle later: we=1, waddr=5, wdata=0xFFFFFF80.
REQ-021 Unsigned halfword load: ExtrWord=2, ExtrSigned=0, addr_lo=3, mem_out=0xBEEF1234, RegDst=1, rd=9 -> waddr=9, wdata=0x0000BEEF.
REQ-022 Priority check: Jal=1 together with MemToReg=1, pc=0x00400010 -> waddr=31, wdata=0x00400010.
REQ-023 MDU stall: LHToReg=2, rd=7, RegDst=1, mdu_busy=1 for 4 cycles, then mdu_done=1 with hi=0xCAFE0001 -> in_ready=0 and stalled=1 for the 4 cycles, then we=1, waddr=7, wdata=0xCAFE0001 one cycle after mdu_done; a second in_valid during the stall is not accepted.
REQ-024 Zero-register write: rt=0, RegDst=0, alu_out=0x55 -> we stays 0.
REQ-025 Reset mid-stall: rst_n pulsed low during WAIT_MDU, then mdu_done=1 -> outputs go to zero immediately and no write ever occurs. With WB_FORWARD_EN defined, fwd_data matches wdata one cycle later across 100 random requests.
